// File: rtl/host_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Package  : host_cmd_pkg
// Purpose  : Frame opcodes, command type and controller state encodings.
// Revision : 1.0
// ============================================================================
package host_cmd_pkg;

  // Leading opcode byte of each frame; the remote controller decodes the same values.
  localparam logic [7:0] c_opc_write = 8'hAA;
  localparam logic [7:0] c_opc_read  = 8'hBB;
  localparam logic [7:0] c_opc_alu   = 8'hCC;
  localparam logic [7:0] c_opc_nop   = 8'hDD;

  typedef enum logic [1:0] {
    CMD_T_WRITE = 2'd0,
    CMD_T_READ  = 2'd1,
    CMD_T_ALU   = 2'd2,
    CMD_T_NOP   = 2'd3
  } cmd_type_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_WAIT_LO = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_DONE    = 3'd4
  } ctrl_state_e;

  // Index of the final byte of the outgoing frame for a given command.
  function automatic logic [1:0] last_byte_idx(input cmd_type_e cmd_type);
    logic [1:0] idx;
    case (cmd_type)
      CMD_T_WRITE: idx = 2'd2;
      CMD_T_READ:  idx = 2'd1;
      CMD_T_ALU:   idx = 2'd3;
      default:     idx = 2'd1;
    endcase
    return idx;
  endfunction

endpackage : host_cmd_pkg
`default_nettype wire

// File: rtl/host_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : host_cmd_ctrl_if
// Purpose   : Command request, TX byte stream, RX byte strobe and response.
// Revision  : 1.0
// ============================================================================
interface host_cmd_ctrl_if #(
  parameter int FRAME_WIDTH    = 8,
  parameter int RF_ADDR_WIDTH  = 4,
  parameter int ALU_FUNC_WIDTH = 4,
  parameter int ALU_DATA_WIDTH = 16
) ();
  import host_cmd_pkg::*;

  logic                      CMD_VLD;
  logic                      CMD_RDY;
  cmd_type_e                 CMD_TYPE;
  logic [RF_ADDR_WIDTH-1:0]  CMD_ADDR;
  logic [FRAME_WIDTH-1:0]    CMD_DATA;
  logic [FRAME_WIDTH-1:0]    CMD_OP_A;
  logic [FRAME_WIDTH-1:0]    CMD_OP_B;
  logic [ALU_FUNC_WIDTH-1:0] CMD_FUNC;

  logic [FRAME_WIDTH-1:0]    TX_P_DATA;
  logic                      TX_VLD;
  logic                      TX_RDY;

  logic [FRAME_WIDTH-1:0]    RX_P_DATA;
  logic                      RX_P_VLD;

  logic [ALU_DATA_WIDTH-1:0] RSP_DATA;
  logic                      RSP_VLD;
  logic                      RSP_ERR;
  logic                      BUSY;

  // Environment side: issues commands, owns the UART link handshakes.
  modport master (
    output CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_DATA, CMD_OP_A, CMD_OP_B, CMD_FUNC,
    output TX_RDY, RX_P_DATA, RX_P_VLD,
    input  CMD_RDY, TX_P_DATA, TX_VLD, RSP_DATA, RSP_VLD, RSP_ERR, BUSY
  );

  // Controller side.
  modport slave (
    input  CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_DATA, CMD_OP_A, CMD_OP_B, CMD_FUNC,
    input  TX_RDY, RX_P_DATA, RX_P_VLD,
    output CMD_RDY, TX_P_DATA, TX_VLD, RSP_DATA, RSP_VLD, RSP_ERR, BUSY
  );

endinterface : host_cmd_ctrl_if
`default_nettype wire

// File: rtl/rsp_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module   : rsp_timeout_cnt
// Purpose  : Idle-cycle counter that flags when the terminal count is reached.
// Revision : 1.0
// ============================================================================
module rsp_timeout_cnt #(
  parameter int WIDTH = 12
) (
  input  wire             clk,
  input  wire             rst,
  input  wire             i_clear,
  input  wire             i_enable,
  input  wire [WIDTH-1:0] i_terminal,
  output logic            o_expired
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Saturates at the terminal value so the flag stays up until cleared.
  always_comb begin
    o_expired = i_enable && (cnt_q == i_terminal);
    cnt_d     = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && !o_expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : rsp_timeout_cnt
`default_nettype wire

// File: rtl/host_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : host_cmd_ctrl
// Purpose  : Serialises host commands into UART frames and collects replies.
// Revision : 1.0
// ============================================================================
module host_cmd_ctrl
  import host_cmd_pkg::*;
#(
  parameter int FRAME_WIDTH    = 8,
  parameter int RF_ADDR_WIDTH  = 4,
  parameter int ALU_FUNC_WIDTH = 4,
  parameter int ALU_DATA_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input wire             CLK,
  input wire             RST,
  host_cmd_ctrl_if.slave bus
);

  localparam int c_cnt_width = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_cnt_width-1:0] c_terminal = c_cnt_width'(TIMEOUT_CYCLES - 1);

  ctrl_state_e               state_q, state_d;
  logic [1:0]                idx_q, idx_d;
  cmd_type_e                 type_q, type_d;
  logic [RF_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [FRAME_WIDTH-1:0]    data_q, data_d;
  logic [FRAME_WIDTH-1:0]    op_a_q, op_a_d;
  logic [FRAME_WIDTH-1:0]    op_b_q, op_b_d;
  logic [ALU_FUNC_WIDTH-1:0] func_q, func_d;
  logic [ALU_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                      rsp_err_q, rsp_err_d;

  logic [FRAME_WIDTH-1:0]    w_tx_byte;
  logic                      w_in_wait;
  logic                      w_tmo_clear;
  logic                      w_expired;

  // ------------------------------------------------------------------------
  // Response timeout: runs only while waiting, restarts on every RX byte.
  // ------------------------------------------------------------------------
  assign w_in_wait   = (state_q == ST_WAIT_LO) || (state_q == ST_WAIT_HI);
  assign w_tmo_clear = !w_in_wait || bus.RX_P_VLD;

  rsp_timeout_cnt #(
    .WIDTH (c_cnt_width)
  ) u_rsp_timeout_cnt (
    .clk        (CLK),
    .rst        (RST),
    .i_clear    (w_tmo_clear),
    .i_enable   (w_in_wait),
    .i_terminal (c_terminal),
    .o_expired  (w_expired)
  );

  // ------------------------------------------------------------------------
  // Outgoing byte selection from the captured command fields.
  // ------------------------------------------------------------------------
  always_comb begin
    w_tx_byte = '0;
    case (type_q)
      CMD_T_WRITE: begin
        case (idx_q)
          2'd0:    w_tx_byte = FRAME_WIDTH'(c_opc_write);
          2'd1:    w_tx_byte = FRAME_WIDTH'(addr_q);
          default: w_tx_byte = data_q;
        endcase
      end
      CMD_T_READ: begin
        case (idx_q)
          2'd0:    w_tx_byte = FRAME_WIDTH'(c_opc_read);
          default: w_tx_byte = FRAME_WIDTH'(addr_q);
        endcase
      end
      CMD_T_ALU: begin
        case (idx_q)
          2'd0:    w_tx_byte = FRAME_WIDTH'(c_opc_alu);
          2'd1:    w_tx_byte = op_a_q;
          2'd2:    w_tx_byte = op_b_q;
          default: w_tx_byte = FRAME_WIDTH'(func_q);
        endcase
      end
      default: begin
        case (idx_q)
          2'd0:    w_tx_byte = FRAME_WIDTH'(c_opc_nop);
          default: w_tx_byte = FRAME_WIDTH'(func_q);
        endcase
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Next-state and response capture.
  // ------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    type_d     = type_q;
    addr_d     = addr_q;
    data_d     = data_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    func_d     = func_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.CMD_VLD) begin
          type_d     = bus.CMD_TYPE;
          addr_d     = bus.CMD_ADDR;
          data_d     = bus.CMD_DATA;
          op_a_d     = bus.CMD_OP_A;
          op_b_d     = bus.CMD_OP_B;
          func_d     = bus.CMD_FUNC;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          idx_d      = 2'd0;
          state_d    = ST_SEND;
        end
      end

      ST_SEND: begin
        if (bus.TX_RDY) begin
          if (idx_q == last_byte_idx(type_q)) begin
            state_d = (type_q == CMD_T_WRITE) ? ST_DONE : ST_WAIT_LO;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      // A byte arriving on the expiry cycle still counts as a valid reply.
      ST_WAIT_LO: begin
        if (bus.RX_P_VLD) begin
          rsp_data_d[FRAME_WIDTH-1:0] = bus.RX_P_DATA;
          state_d = (type_q == CMD_T_READ) ? ST_DONE : ST_WAIT_HI;
        end else if (w_expired) begin
          rsp_err_d = 1'b1;
          state_d   = ST_DONE;
        end
      end

      ST_WAIT_HI: begin
        if (bus.RX_P_VLD) begin
          rsp_data_d[2*FRAME_WIDTH-1:FRAME_WIDTH] = bus.RX_P_DATA;
          state_d = ST_DONE;
        end else if (w_expired) begin
          rsp_err_d = 1'b1;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      type_q     <= CMD_T_WRITE;
      addr_q     <= '0;
      data_q     <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      func_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      type_q     <= type_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      func_q     <= func_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // ------------------------------------------------------------------------
  // Outputs decoded from the registered state.
  // ------------------------------------------------------------------------
  assign bus.CMD_RDY   = (state_q == ST_IDLE);
  assign bus.BUSY      = (state_q != ST_IDLE);
  assign bus.TX_VLD    = (state_q == ST_SEND);
  assign bus.TX_P_DATA = (state_q == ST_SEND) ? w_tx_byte : '0;
  assign bus.RSP_VLD   = (state_q == ST_DONE);
  assign bus.RSP_DATA  = rsp_data_q;
  assign bus.RSP_ERR   = rsp_err_q;

endmodule : host_cmd_ctrl
`default_nettype wire

// File: tb/tb_host_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_host_cmd_ctrl
// Purpose  : Directed and randomised checks of host_cmd_ctrl against a frame model.
// Revision : 1.0
// ============================================================================
module tb_host_cmd_ctrl;

  localparam int T = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  host_cmd_ctrl_if #(
    .FRAME_WIDTH(8), .RF_ADDR_WIDTH(4), .ALU_FUNC_WIDTH(4), .ALU_DATA_WIDTH(16)
  ) bus ();

  host_cmd_ctrl #(
    .FRAME_WIDTH(8), .RF_ADDR_WIDTH(4), .ALU_FUNC_WIDTH(4), .ALU_DATA_WIDTH(16),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    bus.RX_P_VLD  = 1'b1;
    bus.RX_P_DATA = b;
    tick();
    bus.RX_P_VLD  = 1'b0;
  endtask

  function automatic logic [28:0] outs();
    return {bus.CMD_RDY, bus.TX_VLD, bus.TX_P_DATA, bus.RSP_DATA,
            bus.RSP_VLD, bus.RSP_ERR, bus.BUSY};
  endfunction

  // One complete command: frame built from the byte-level frame rules, reply
  // value assembled from the bytes actually returned, timeout when short.
  // noise: 0 none, 1 random RX strobes in SEND/DONE, 2 RX strobe every SEND cycle.
  task automatic run_cmd(input int t, input logic [3:0] addr, input logic [7:0] data,
                         input logic [7:0] a, input logic [7:0] b, input logic [3:0] func,
                         input int rdy_mode, input int provide,
                         input logic [7:0] r0, input logic [7:0] r1,
                         input int d0, input int d1, input int noise);
    logic [7:0]  frame[$];
    int          needed;
    logic [15:0] exp_rsp;
    logic        exp_err;
    int          k;
    int          guard;
    int          lat;
    logic        rdy;

    case (t)
      0:       frame = '{8'hAA, {4'h0, addr}, data};
      1:       frame = '{8'hBB, {4'h0, addr}};
      2:       frame = '{8'hCC, a, b, {4'h0, func}};
      default: frame = '{8'hDD, {4'h0, func}};
    endcase
    needed  = (t == 0) ? 0 : ((t == 1) ? 1 : 2);
    exp_rsp = 16'h0000;
    if (provide >= 1) exp_rsp[7:0]  = r0;
    if (provide >= 2) exp_rsp[15:8] = r1;
    exp_err = (provide < needed);

    bus.CMD_TYPE = host_cmd_pkg::cmd_type_e'(2'(t));
    bus.CMD_ADDR = addr;
    bus.CMD_DATA = data;
    bus.CMD_OP_A = a;
    bus.CMD_OP_B = b;
    bus.CMD_FUNC = func;
    bus.CMD_VLD  = 1'b1;
    check("cmd_rdy_idle", bus.CMD_RDY, 1);
    tick();

    // Keep requesting with scrambled fields: must be ignored while busy.
    bus.CMD_TYPE = host_cmd_pkg::cmd_type_e'(2'($urandom));
    bus.CMD_ADDR = 4'($urandom);
    bus.CMD_DATA = 8'($urandom);
    bus.CMD_OP_A = 8'($urandom);
    bus.CMD_OP_B = 8'($urandom);
    bus.CMD_FUNC = 4'($urandom);
    check("busy_after_accept", bus.BUSY, 1);
    check("cmd_rdy_busy", bus.CMD_RDY, 0);

    k = 0;
    guard = 0;
    while (k < frame.size() && guard < 64) begin
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = guard[0];
        default: rdy = 1'($urandom);
      endcase
      bus.TX_RDY = rdy;
      if (noise == 1) begin
        bus.RX_P_VLD  = 1'($urandom);
        bus.RX_P_DATA = 8'($urandom);
      end else if (noise == 2) begin
        bus.RX_P_VLD  = 1'b1;
        bus.RX_P_DATA = 8'($urandom);
      end
      check("tx_vld", bus.TX_VLD, 1);
      check("tx_byte", bus.TX_P_DATA, frame[k]);
      tick();
      if (rdy) k++;
      guard++;
    end
    bus.TX_RDY   = 1'b0;
    bus.RX_P_VLD = 1'b0;
    bus.CMD_VLD  = 1'b0;
    check("tx_vld_after_frame", bus.TX_VLD, 0);

    if (provide >= 1) begin
      repeat (d0) tick();
      rx_pulse(r0);
    end
    if (provide >= 2) begin
      repeat (d1) tick();
      rx_pulse(r1);
    end

    lat = 0;
    while (bus.RSP_VLD !== 1'b1 && lat < T + 16) begin
      tick();
      lat++;
    end
    check("rsp_vld", bus.RSP_VLD, 1);
    check("rsp_latency", lat, exp_err ? T : 0);
    check("rsp_data", bus.RSP_DATA, exp_rsp);
    check("rsp_err", bus.RSP_ERR, exp_err);
    check("busy_in_done", bus.BUSY, 1);
    if (noise != 0) begin
      bus.RX_P_VLD  = 1'b1;
      bus.RX_P_DATA = 8'($urandom);
    end
    tick();
    bus.RX_P_VLD = 1'b0;
    check("rsp_vld_one_cycle", bus.RSP_VLD, 0);
    check("cmd_rdy_back", bus.CMD_RDY, 1);
    check("busy_idle", bus.BUSY, 0);
  endtask

  initial begin
    int          rt;
    int          rneed;
    int          rprov;
    logic [28:0] snap;
    logic        saw;

    rst           = 1'b1;
    bus.CMD_VLD   = 1'b0;
    bus.CMD_TYPE  = host_cmd_pkg::cmd_type_e'(2'd0);
    bus.CMD_ADDR  = '0;
    bus.CMD_DATA  = '0;
    bus.CMD_OP_A  = '0;
    bus.CMD_OP_B  = '0;
    bus.CMD_FUNC  = '0;
    bus.TX_RDY    = 1'b0;
    bus.RX_P_DATA = '0;
    bus.RX_P_VLD  = 1'b0;
    tick();
    tick();
    check("rst_cmd_rdy", bus.CMD_RDY, 1);
    check("rst_tx_vld", bus.TX_VLD, 0);
    check("rst_tx_data", bus.TX_P_DATA, 0);
    check("rst_rsp_data", bus.RSP_DATA, 0);
    check("rst_rsp_vld", bus.RSP_VLD, 0);
    check("rst_rsp_err", bus.RSP_ERR, 0);
    check("rst_busy", bus.BUSY, 0);
    rst = 1'b0;
    tick();

    // Write addr 5 data 3C, TX always ready.
    run_cmd(0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    // Read addr 2, TX ready every other cycle, reply 7E.
    run_cmd(1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 1, 1, 8'h7E, 8'h00, 3, 0, 0);
    // ALU 0A + 14, replies 1E then 00.
    run_cmd(2, 4'h0, 8'h00, 8'h0A, 8'h14, 4'h0, 0, 2, 8'h1E, 8'h00, 2, 1, 0);
    // NOP func 2, only one byte back: timeout keeps 0034.
    run_cmd(3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2, 0, 1, 8'h34, 8'h00, 1, 0, 0);

    // Stray RX strobe in IDLE changes nothing.
    snap = outs();
    rx_pulse(8'hC3);
    check("stray_rx_idle", outs(), snap);

    // RX on the expiry cycle wins in both wait states.
    run_cmd(1, 4'hF, 8'h00, 8'h00, 8'h00, 4'h0, 0, 1, 8'hA5, 8'h00, T - 1, 0, 0);
    run_cmd(2, 4'h3, 8'h00, 8'h55, 8'h66, 4'h7, 2, 2, 8'h12, 8'h9B, 0, T - 1, 0);
    // RX asserted across all SEND cycles, including the last handshake.
    run_cmd(1, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0, 0, 1, 8'h5A, 8'h00, 0, 0, 2);
    // ALU with no reply at all.
    run_cmd(2, 4'h0, 8'h00, 8'h01, 8'h02, 4'hF, 1, 0, 8'h00, 8'h00, 0, 0, 0);

    // Reset while the third ALU byte is on the link.
    bus.CMD_TYPE = host_cmd_pkg::cmd_type_e'(2'd2);
    bus.CMD_OP_A = 8'h11;
    bus.CMD_OP_B = 8'h22;
    bus.CMD_FUNC = 4'h3;
    bus.CMD_VLD  = 1'b1;
    tick();
    bus.CMD_VLD  = 1'b0;
    bus.TX_RDY   = 1'b1;
    tick();
    tick();
    bus.TX_RDY   = 1'b0;
    check("pre_reset_byte2", bus.TX_P_DATA, 8'h22);
    rst = 1'b1;
    tick();
    check("abort_tx_vld", bus.TX_VLD, 0);
    check("abort_cmd_rdy", bus.CMD_RDY, 1);
    check("abort_busy", bus.BUSY, 0);
    check("abort_rsp_vld", bus.RSP_VLD, 0);
    check("abort_tx_data", bus.TX_P_DATA, 0);
    rst = 1'b0;
    saw = 1'b0;
    repeat (T + 8) begin
      tick();
      if (bus.RSP_VLD === 1'b1) saw = 1'b1;
    end
    check("abort_no_rsp", saw, 0);
    snap = outs();
    rx_pulse(8'h3F);
    check("stray_rx_after_abort", outs(), snap);

    // Randomised commands.
    for (int i = 0; i < 24; i++) begin
      rt    = $urandom_range(0, 3);
      rneed = (rt == 0) ? 0 : ((rt == 1) ? 1 : 2);
      rprov = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rneed) : rneed;
      run_cmd(rt, 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
              $urandom_range(0, 2), rprov, 8'($urandom), 8'($urandom),
              $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: bench did not complete, observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_host_cmd_ctrl
`default_nettype wire

// File: doc/host_cmd_ctrl.md
HOST_CMD_CTRL -- requirements
Module: host_cmd_ctrl

Interface
REQ-001 Parameters: FRAME_WIDTH, default 8, UART byte width.
REQ-002 Parameters: RF_ADDR_WIDTH, default 4, register-file address width.
REQ-003 Parameters: ALU_FUNC_WIDTH, default 4, ALU function code width.
REQ-004 Parameters: ALU_DATA_WIDTH, default 16, ALU result width; shall equal 2*FRAME_WIDTH.
REQ-005 Parameters: TIMEOUT_CYCLES, default 4096, maximum idle cycles between response bytes.
REQ-006 Port: CLK  in  1  single clock, all logic on its rising edge.
REQ-007 Port: RST  in  1  synchronous, active-high reset.
REQ-008 Port: CMD_VLD  in  1  command request valid.
REQ-009 Port: CMD_RDY  out  1  command accepted when CMD_VLD and CMD_RDY are both high.
REQ-010 Port: CMD_TYPE  in  2  0 = RF write, 1 = RF read, 2 = ALU with operands, 3 = ALU without operands.
REQ-011 Port: CMD_ADDR  in  RF_ADDR_WIDTH  register-file address for write and read.
REQ-012 Port: CMD_DATA  in  FRAME_WIDTH  write data.
REQ-013 Port: CMD_OP_A / CMD_OP_B  in  FRAME_WIDTH each  ALU operands.
REQ-014 Port: CMD_FUNC  in  ALU_FUNC_WIDTH  ALU function.
REQ-015 Port: TX_P_DATA  out  FRAME_WIDTH  outgoing frame byte.
REQ-016 Port: TX_VLD  out  1  outgoing byte valid.
REQ-017 Port: TX_RDY  in  1  transmitter accepts the byte on TX_VLD and TX_RDY both high.
REQ-018 Port: RX_P_DATA  in  FRAME_WIDTH  received response byte.
REQ-019 Port: RX_P_VLD  in  1  one-cycle strobe per received byte.
REQ-020 Port: RSP_DATA  out  ALU_DATA_WIDTH  response value.
REQ-021 Port: RSP_VLD  out  1  one-cycle completion pulse.
REQ-022 Port: RSP_ERR  out  1  timeout flag, qualified by RSP_VLD.
REQ-023 Port: BUSY  out  1  high whenever the FSM is not in IDLE.

Function
REQ-024 States shall be IDLE, SEND (byte index 0..3), WAIT_LO, WAIT_HI and DONE; CMD_RDY is high only in IDLE.
REQ-025 On accept, all CMD_* fields shall be registered, and the FSM shall enter SEND with index 0 on the next cycle.
REQ-026 Frames, sent in order: write = AA, addr, data; read = BB, addr; ALU = CC, A, B, {0,func}; NOP = DD, {0,func}. The addr field shall be zero-extended to FRAME_WIDTH.
REQ-027 In SEND, TX_VLD shall be high and TX_P_DATA shall hold the current byte stable until the handshake; each handshake advances the index by one byte per cycle at most.
REQ-028 After the last byte handshake, the FSM shall go as follows: write -> DONE; read -> WAIT_LO; ALU/NOP -> WAIT_LO.
REQ-029 Read: the first RX_P_VLD in WAIT_LO shall set RSP_DATA = {8'h00, byte} and go to DONE.
REQ-030 ALU/NOP: the first byte is RSP_DATA[7:0] (WAIT_LO -> WAIT_HI), and the second byte is RSP_DATA[15:8] (-> DONE).
REQ-031 DONE shall last exactly one cycle with RSP_VLD = 1, then return to IDLE; a write completes with RSP_DATA = 0 and RSP_ERR = 0.
REQ-032 The timeout counter shall clear on entry to WAIT_LO and on every RX_P_VLD in a wait state. When it reaches TIMEOUT_CYCLES-1, the FSM shall go to DONE with RSP_ERR = 1, keeping any bytes already received in RSP_DATA and zero in the rest.
REQ-033 RX_P_VLD in IDLE, SEND or DONE shall be ignored, including when it coincides with the last TX handshake; RX_P_VLD coinciding with the timeout expiry cycle shall win, with the byte captured and no error.
REQ-034 CMD_VLD while BUSY shall be ignored, and no command is queued.

Reset
REQ-035 When RST is high at a clock edge, the block shall go to IDLE and set CMD_RDY = 1, TX_VLD = 0, TX_P_DATA = 0, RSP_DATA = 0, RSP_VLD = 0, RSP_ERR = 0, BUSY = 0, and clear the timeout counter.
REQ-036 Reset mid-frame shall abandon the command with no RSP_VLD; TX_VLD shall be low from the cycle after reset is sampled.

Structure
REQ-037 A shared package host_cmd_pkg shall hold the opcode constants (AA, BB, CC, DD), the CMD_TYPE encodings and the FSM state encoding; the controller on the receiving end shall import the same opcode constants.
REQ-038 The timeout counter shall be a sub-module rsp_timeout_cnt (inputs: clear, enable, terminal value; output: expired); the FSM, byte mux and response registers shall stay in host_cmd_ctrl.

Verification
REQ-039 Write (addr 5, data 3C) with TX_RDY always high -> TX bytes AA, 05, 3C on 3 consecutive cycles; RSP_VLD pulse with RSP_DATA = 0000 and RSP_ERR = 0.
REQ-040 Read (addr 2) with TX_RDY toggling every other cycle -> bytes BB, 02 each held until handshake; RX byte 7E -> RSP_DATA = 007E, RSP_ERR = 0.
REQ-041 ALU (A = 0A, B = 14, func = 0) -> bytes CC, 0A, 14, 00; RX bytes 1E then 00 -> RSP_DATA = 001E.
REQ-042 NOP (func = 2) -> bytes DD, 02; only one RX byte 34 arrives -> after TIMEOUT_CYCLES, RSP_VLD with RSP_ERR = 1 and RSP_DATA = 0034.
REQ-043 Reset asserted during byte 2 of an ALU frame -> TX_VLD low and CMD_RDY high the next cycle, no RSP_VLD; a stray RX_P_VLD in IDLE leaves all outputs unchanged.
